// File: rtl/uart_reply_sched.sv
// uart_reply_sched: shares one UART transmitter between 4-byte reply frames and echoed RX bytes.
// Define UART_REPLY_ECHO_EN to build the echo FIFO; without it only reply frames are sent.
module uart_reply_sched #(
  parameter int unsigned ECHO_DEPTH = 8,
  parameter int unsigned ECHO_AW    = 3,
  parameter logic [7:0]  PROMPT     = 8'h3E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       match,
  input  logic [7:0] match_result,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       echo_ovf,
  output logic       reply_drop
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  function automatic logic [7:0] reply_byte(input logic [1:0] idx, input logic [7:0] res);
    logic [7:0] b;
    case (idx)
      2'd0:    b = PROMPT;
      2'd1:    b = res;
      2'd2:    b = 8'h0D;
      2'd3:    b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       active_q, active_d;
  logic [7:0] active_res_q, active_res_d;
  logic       pend_q, pend_d;
  logic [7:0] pend_res_q, pend_res_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       busy_q, busy_d;
  logic       echo_ovf_q, echo_ovf_d;
  logic       reply_drop_q, reply_drop_d;

  logic       fifo_empty_s;
  logic [7:0] fifo_head_s;
  logic       pop_s;
  logic       ovf_s;

`ifdef UART_REPLY_ECHO_EN
  localparam logic [ECHO_AW:0] DEPTH_C = (ECHO_AW + 1)'(ECHO_DEPTH);

  logic [7:0]         mem_q [ECHO_DEPTH];
  logic [ECHO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [ECHO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [ECHO_AW:0]   count_q, count_d;
  logic               fifo_full_s;
  logic               push_s;

  // Fullness is judged on the registered count, so a same-cycle pop never frees room for a push.
  assign fifo_full_s  = (count_q == DEPTH_C);
  assign fifo_empty_s = (count_q == '0);
  assign fifo_head_s  = mem_q[rd_ptr_q];
  assign push_s       = rx_valid & ~fifo_full_s;
  assign ovf_s        = rx_valid & fifo_full_s;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + ECHO_AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + ECHO_AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (ECHO_AW + 1)'(1);
      2'b01:   count_d = count_q - (ECHO_AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end
`else
  logic unused_s;

  assign fifo_empty_s = 1'b1;
  assign fifo_head_s  = 8'h00;
  assign ovf_s        = 1'b0;
  assign unused_s     = ^{rx_valid, rx_data, pop_s, ECHO_DEPTH[0], ECHO_AW[0]};
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    active_d     = active_q;
    active_res_d = active_res_q;
    pend_d       = pend_q;
    pend_res_d   = pend_res_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    reply_drop_d = 1'b0;
    echo_ovf_d   = ovf_s;
    pop_s        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_ready) begin
          if (active_q) begin
            tx_start_d = 1'b1;
            tx_data_d  = reply_byte(idx_q, active_res_q);
            state_d    = ST_HOLD;
            if (idx_q == 2'd3) begin
              active_d = 1'b0;
              idx_d    = 2'd0;
            end else begin
              idx_d    = idx_q + 2'd1;
            end
          end else if (pend_q) begin
            // Starting a frame moves the pending result into the active slot.
            tx_start_d   = 1'b1;
            tx_data_d    = reply_byte(2'd0, pend_res_q);
            active_d     = 1'b1;
            active_res_d = pend_res_q;
            pend_d       = 1'b0;
            idx_d        = 2'd1;
            state_d      = ST_HOLD;
          end else if (!fifo_empty_s) begin
            tx_start_d = 1'b1;
            tx_data_d  = fifo_head_s;
            pop_s      = 1'b1;
            state_d    = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new match always lands in the pending slot, evaluated after any same-cycle promotion.
    if (match) begin
      reply_drop_d = pend_d;
      pend_d       = 1'b1;
      pend_res_d   = match_result;
    end else begin
      reply_drop_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE) | active_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      active_q     <= 1'b0;
      active_res_q <= 8'h00;
      pend_q       <= 1'b0;
      pend_res_q   <= 8'h00;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      busy_q       <= 1'b0;
      echo_ovf_q   <= 1'b0;
      reply_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      active_res_q <= active_res_d;
      pend_q       <= pend_d;
      pend_res_q   <= pend_res_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      echo_ovf_q   <= echo_ovf_d;
      reply_drop_q <= reply_drop_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign busy       = busy_q;
  assign echo_ovf   = echo_ovf_q;
  assign reply_drop = reply_drop_q;

endmodule

// File: tb/tb_uart_reply_sched.sv
// Bench for uart_reply_sched: directed scenarios plus random traffic checked against a queue model
// of pending/active replies and the echo backlog.
module tb_uart_reply_sched;

  localparam logic [7:0] PROMPT = 8'h3E;
  localparam int DEPTH = 8;
`ifdef UART_REPLY_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       match = 1'b0;
  logic [7:0] match_result = 8'h00;
  logic       tx_ready = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       echo_ovf;
  logic       reply_drop;

  uart_reply_sched dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .match(match), .match_result(match_result), .tx_ready(tx_ready),
    .tx_start(tx_start), .tx_data(tx_data), .busy(busy),
    .echo_ovf(echo_ovf), .reply_drop(reply_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int lo_cnt = 0;
  bit rdy_en = 1'b1;
  int last_tx_cyc = -100;
  int ovf_seen = 0;
  int drop_seen = 0;

  // reference model: bytes left in the current frame, one pending result, echo backlog
  logic [7:0] frm_q[$];
  logic [7:0] eq[$];
  logic [7:0] sent_q[$];
  logic [7:0] exp_a[$];
  bit         pend_v = 1'b0;
  logic [7:0] pend_r = 8'h00;

  task automatic model_clear();
    frm_q.delete();
    eq.delete();
    pend_v = 1'b0;
    lo_cnt = 0;
    last_tx_cyc = -100;
  endtask

  task automatic step(input logic m, input logic [7:0] mr, input logic rv, input logic [7:0] rd);
    int sz;
    logic [7:0] exp_b;
    bit exp_drop;
    bit exp_ovf;
    match = m; match_result = mr; rx_valid = rv; rx_data = rd;
    tx_ready = rdy_en && (lo_cnt == 0);
    @(posedge clk);
    #1;
    cyc++;
    if (lo_cnt > 0) lo_cnt--;
    sz = eq.size();
    exp_drop = 1'b0;
    exp_ovf = 1'b0;
    if (tx_start) begin
      sent_q.push_back(tx_data);
      n_checks++;
      if (frm_q.size() > 0) begin
        exp_b = frm_q.pop_front();
      end else if (pend_v) begin
        frm_q = {PROMPT, pend_r, 8'h0D, 8'h0A};
        pend_v = 1'b0;
        exp_b = frm_q.pop_front();
      end else if (eq.size() > 0) begin
        exp_b = eq.pop_front();
      end else begin
        exp_b = 8'hxx;
      end
      if (exp_b === 8'hxx) $display("FAIL unexpected_tx_start: got byte %h at cycle %0d, required no tx_start", tx_data, cyc);
      else if (tx_data !== exp_b) $display("FAIL tx_byte: got %h required %h (cycle %0d)", tx_data, exp_b, cyc);
      else n_pass++;
      n_checks++;
      if (cyc - last_tx_cyc < 3) $display("FAIL byte_gap: got %0d cycles required >=3", cyc - last_tx_cyc);
      else n_pass++;
      last_tx_cyc = cyc;
      lo_cnt = $urandom_range(1, 3);
    end
    if (m) begin
      exp_drop = pend_v;
      pend_v = 1'b1;
      pend_r = mr;
    end
    if (ECHO && rv) begin
      if (sz >= DEPTH) exp_ovf = 1'b1;
      else eq.push_back(rd);
    end
    if (reply_drop) drop_seen++;
    if (echo_ovf) ovf_seen++;
    n_checks++;
    if (reply_drop !== exp_drop) $display("FAIL reply_drop: got %b required %b (cycle %0d)", reply_drop, exp_drop, cyc);
    else n_pass++;
    n_checks++;
    if (echo_ovf !== exp_ovf) $display("FAIL echo_ovf: got %b required %b (cycle %0d)", echo_ovf, exp_ovf, cyc);
    else n_pass++;
    if (tx_start || frm_q.size() > 0) begin
      n_checks++;
      if (busy !== 1'b1) $display("FAIL busy_in_frame: got %b required 1 (cycle %0d)", busy, cyc);
      else n_pass++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && !(frm_q.size() == 0 && !pend_v && eq.size() == 0 && lo_cnt == 0); i++)
      idle(1);
    n_checks++;
    if (frm_q.size() + eq.size() + int'(pend_v) != 0)
      $display("FAIL drain_timeout: got %0d bytes outstanding required 0", frm_q.size() + eq.size() + int'(pend_v) * 4);
    else n_pass++;
    idle(4);
  endtask

  task automatic wait_sent(input int n, input int budget);
    for (int i = 0; i < budget && sent_q.size() < n; i++) idle(1);
    n_checks++;
    if (sent_q.size() < n) $display("FAIL wait_sent: got %0d bytes required %0d", sent_q.size(), n);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; match = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b required 0", tx_start); else n_pass++;
    n_checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h required 00", tx_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
    n_checks++; if (echo_ovf !== 1'b0) $display("FAIL reset_echo_ovf: got %b required 0", echo_ovf); else n_pass++;
    n_checks++; if (reply_drop !== 1'b0) $display("FAIL reset_reply_drop: got %b required 0", reply_drop); else n_pass++;
    rst = 1'b0;
    model_clear();
    idle(5);
  endtask

  task automatic test_single_frame();
    int mcyc;
    sent_q.delete();
    step(1'b1, 8'h31, 1'b0, 8'h00);
    mcyc = cyc;
    wait_sent(1, 10);
    n_checks++;
    if (cyc - mcyc != 1) $display("FAIL first_latency: got %0d cycles required 1", cyc - mcyc);
    else n_pass++;
    for (int i = 0; i < 40 && sent_q.size() < 4; i++) begin
      idle(1);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL busy_frame: got %b required 1", busy);
      else n_pass++;
    end
    drain(40);
    exp_a = {8'h3E, 8'h31, 8'h0D, 8'h0A};
    n_checks++;
    if (sent_q != exp_a) $display("FAIL single_frame_seq: got %p required %p", sent_q, exp_a);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL busy_after_frame: got %b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_drop();
    sent_q.delete();
    drop_seen = 0;
    step(1'b1, 8'h31, 1'b0, 8'h00);
    wait_sent(1, 10);
    step(1'b1, 8'h32, 1'b0, 8'h00);
    step(1'b1, 8'h33, 1'b0, 8'h00);
    drain(80);
    n_checks++;
    if (drop_seen != 1) $display("FAIL drop_count: got %0d required 1", drop_seen);
    else n_pass++;
    exp_a = {8'h3E, 8'h31, 8'h0D, 8'h0A, 8'h3E, 8'h33, 8'h0D, 8'h0A};
    n_checks++;
    if (sent_q != exp_a) $display("FAIL drop_seq: got %p required %p", sent_q, exp_a);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    sent_q.delete();
    step(1'b1, 8'h32, 1'b0, 8'h00);
    wait_sent(2, 20);
    match = 1'b0; rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (tx_start !== 1'b0) $display("FAIL midrst_tx_start: got %b required 0", tx_start); else n_pass++;
    n_checks++; if (tx_data !== 8'h00) $display("FAIL midrst_tx_data: got %h required 00", tx_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b required 0", busy); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    sent_q.delete();
    idle(20);
    n_checks++;
    if (sent_q.size() != 0) $display("FAIL after_reset_silent: got %0d bytes required 0", sent_q.size());
    else n_pass++;
  endtask

`ifdef UART_REPLY_ECHO_EN
  task automatic test_echo_after_frame();
    sent_q.delete();
    step(1'b1, 8'h31, 1'b0, 8'h00);
    wait_sent(1, 10);
    step(1'b0, 8'h00, 1'b1, 8'h61);
    step(1'b0, 8'h00, 1'b1, 8'h62);
    step(1'b0, 8'h00, 1'b1, 8'h63);
    drain(80);
    exp_a = {8'h3E, 8'h31, 8'h0D, 8'h0A, 8'h61, 8'h62, 8'h63};
    n_checks++;
    if (sent_q != exp_a) $display("FAIL echo_after_frame: got %p required %p", sent_q, exp_a);
    else n_pass++;
  endtask

  task automatic test_overflow();
    sent_q.delete();
    ovf_seen = 0;
    rdy_en = 1'b0;
    idle(2);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 8'(8'h40 + i));
    idle(2);
    n_checks++;
    if (ovf_seen != 1) $display("FAIL ovf_count: got %0d required 1", ovf_seen);
    else n_pass++;
    rdy_en = 1'b1;
    drain(120);
    exp_a = {8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
    n_checks++;
    if (sent_q != exp_a) $display("FAIL ovf_seq: got %p required %p", sent_q, exp_a);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    sent_q.delete();
    step(1'b1, 8'h32, 1'b1, 8'h5A);
    drain(60);
    exp_a = {8'h3E, 8'h32, 8'h0D, 8'h0A, 8'h5A};
    n_checks++;
    if (sent_q != exp_a) $display("FAIL simultaneous_seq: got %p required %p", sent_q, exp_a);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic       m;
    logic       rv;
    logic [7:0] mr;
    logic [7:0] rd;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) rdy_en = ~rdy_en;
      m  = ($urandom_range(0, 39) == 0);
      mr = 8'(8'h30 + $urandom_range(0, 3));
      rv = ($urandom_range(0, 4) == 0);
      rd = 8'($urandom);
      step(m, mr, rv, rd);
    end
    rdy_en = 1'b1;
    drain(600);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_drop();
`ifdef UART_REPLY_ECHO_EN
    test_echo_after_frame();
    test_overflow();
    test_simultaneous();
`endif
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
